regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the register file's single write port (`ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`) between several writeback sources, such as the pipeline writeback stage and the multicycle mult/div unit. It uses round-robin arbitration with a valid/ready handshake. It also keeps a per-register pending-write scoreboard so decode can stall on registers whose multicycle result has not yet landed. It sits between the writeback sources and `regfile`, and drives the write-side control inputs of `regfile` directly.

## Interface
- `NUM_REQ`, default 2: number of writeback requesters; legal range 2..4.
- `ADDR_W`, default 5: register address width; must equal the package constant.
- `DATA_W`, default 32: register data width.

Ports:
- `clock` in, 1: single clock. Rising edge is active for this block.
- `ctrl_reset` in, 1: synchronous, active-high reset.
- `req_valid` in, NUM_REQ: requester i has a write pending.
- `req_ready` out, NUM_REQ: grant for requester i. A handshake occurs when `req_valid[i] & req_ready[i]`.
- `req_reg` in, NUM_REQ*ADDR_W: destination register of requester i, packed as slice i.
- `req_data` in, NUM_REQ*DATA_W: write data of requester i, packed as slice i.
- `claim_valid` in, 1: a multicycle op has issued and will write `claim_reg` later.
- `claim_reg` in, ADDR_W: register to mark pending.
- `wr_en` out, 1: drives `ctrl_writeEnable` of `regfile`.
- `wr_reg` out, ADDR_W: drives `ctrl_writeReg` of `regfile`.
- `wr_data` out, DATA_W: drives `data_writeReg` of `regfile`.
- `busy_mask` out, 32: bit r is 1 while register r has a claimed, uncompleted write.

## Operation
- **Requester rules.**
  - Once `req_valid[i]` is high, it stays high with stable `req_reg`/`req_data` until the handshake.
  - `req_ready` is combinational from `req_valid` and the arbiter pointer.
  - At most one `req_ready` bit is high per cycle.
- **Round-robin arbitration.**
  - Pointer `last` holds the index of the most recent grant.
  - The grant goes to the first valid index scanning from `last+1` and wrapping modulo NUM_REQ.
  - `last` updates only on a handshake.
  - With no valid requests, no ready is asserted and `last` holds.
- **Handshake in cycle N.**
  - `wr_en`/`wr_reg`/`wr_data` register the winning request at the edge ending N.
  - These outputs are high/valid for exactly cycle N+1 unless another handshake follows back-to-back.
  - Sustained throughput is one write per cycle.
- **Register 0.**
  - A request to r0 still handshakes and advances `last`.
  - It produces `wr_en`=0 for that slot.
  - `claim_reg`=0 is ignored, so `busy_mask[0]` is always 0.
- **Scoreboard set.** `claim_valid` sets `busy[claim_reg]` at the edge ending its cycle.
- **Scoreboard clear.** A committed write (`wr_en`=1 in cycle N+1) clears `busy[wr_reg]` at the edge ending N+1.
- **Clear vs. set priority.** If a claim and a clear hit the same register on the same edge, the claim wins and the bit stays 1.
- **Double claim.** Claiming an already-busy register leaves it busy; there is no counting. A write to a non-busy register is legal and leaves the bit 0.

## Timing
- **Reset values:**
  - `wr_en`=0, `wr_reg`=0, `wr_data`=0.
  - `busy_mask`=0.
  - `last`=NUM_REQ-1, so requester 0 wins first after reset.
  - `req_ready` is forced to 0 in every cycle where `ctrl_reset`=1.
- **Reset mid-operation:**
  - An in-flight registered write is dropped (`wr_en`=0 the next cycle).
  - All busy bits are cleared.
  - Requesters must re-present their requests.
- **Latency:**
  - Handshake to `wr_en` is 1 cycle.
  - `regfile` writes on the falling edge of `clock` inside cycle N+1, so read ports show the new value from the second half of N+1.
  - `busy_mask` falls at the start of N+2.
- **Combinational paths:** `busy_mask` is a direct register output with no combinational path from inputs.

## Structure
- **Package `regfile_pkg`:**
  - `REG_ADDR_W`=5, `REG_DATA_W`=32, `NUM_REGS`=32, `ZERO_REG`=0.
  - Typedefs `reg_addr_t`, `reg_data_t`.
- **Sub-module `rr_arbiter`:** parameterised on N. Inputs are `clock`, `ctrl_reset`, request vector and handshake-done. Outputs are a one-hot grant and the `last` pointer.
- **Top level:** instantiates `rr_arbiter` and holds the output register and 32-bit scoreboard.

## Test plan
- **Reset defaults:** after reset with no activity, all outputs are 0. Then `req_valid`=2'b11 → `req_ready`=2'b01, and the next cycle `wr_en`=1, `wr_reg`/`wr_data` = requester 0's values.
- **Fairness:** both requesters held valid for 4 handshakes (req0 → r5/0xAAAA0000, req1 → r6/0x5555FFFF) → grants alternate 0,1,0,1, with `wr_en` high 4 consecutive cycles.
- **Register 0:** request to r0 with data 0xDEADBEEF → handshake occurs, `wr_en` stays 0, and register 0 reads 0.
- **Scoreboard:** claim r7 → `busy_mask`=0x80 next cycle. req1 writes r7 → `busy_mask` returns to 0 two cycles after the handshake. Claim and clear of r7 on the same edge → bit stays 1.
- **Reset mid-operation:** `ctrl_reset` asserted in the handshake cycle of req0 → r9 → `wr_en`=0 afterwards, `busy_mask`=0, and the next grant goes to requester 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the write-port arbiter and its users.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning from last+1, pointer moves only on a handshake.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 clock,
  input  logic                 ctrl_reset,
  input  logic [N-1:0]         req,
  input  logic                 hs_done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] last
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] idx;
  logic             found;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    grant   = '0;
    win_idx = last;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        win_idx    = idx;
        found      = 1'b1;
      end
    end
    // Nothing may handshake while reset is held.
    if (ctrl_reset) grant = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (ctrl_reset)   last <= IDX_W'(N - 1);
    else if (hs_done) last <= win_idx;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the regfile write port plus a pending-write scoreboard for decode stalls.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      claim_valid,
  input  logic [ADDR_W-1:0]         claim_reg,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_reg,
  output logic [DATA_W-1:0]         wr_data,
  output logic [NUM_REGS-1:0]       busy_mask
);

  logic [NUM_REQ-1:0]         grant;
  logic [$clog2(NUM_REQ)-1:0] last;
  logic                       hs;
  logic [ADDR_W-1:0]          sel_reg;
  logic [DATA_W-1:0]          sel_data;
  logic [NUM_REGS-1:0]        busy_next;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .req        (req_valid),
    .hs_done    (hs),
    .grant      (grant),
    .last       (last)
  );

  assign req_ready = grant;
  assign hs        = |(req_valid & grant);

  // Grant is one-hot, so OR-ing the masked slices is the mux.
  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_reg  = sel_reg  | req_reg[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writes to r0 still consume their slot but never enable the regfile.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      wr_en   <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= hs && (sel_reg != ADDR_W'(ZERO_REG));
      if (hs) begin
        wr_reg  <= sel_reg;
        wr_data <= sel_data;
      end
    end
  end

  // Clear first, then set, so a same-edge claim wins over the landing write.
  always_comb begin
    busy_next = busy_mask;
    if (wr_en) busy_next[wr_reg] = 1'b0;
    if (claim_valid && claim_reg != ADDR_W'(ZERO_REG)) busy_next[claim_reg] = 1'b1;
  end

  // NOTE: the scoreboard is plain flops rather than a RAM, so it is cleared in
  // full by a single reset cycle.
  always_ff @(posedge clock) begin
    if (ctrl_reset) busy_mask <= '0;
    else            busy_mask <= busy_next;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised + directed bench; writes are checked through an expected-write queue by a monitor.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int NUM_REQ = 2;

  logic                          clock = 1'b0;
  logic                          ctrl_reset;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*REG_ADDR_W-1:0] req_reg;
  logic [NUM_REQ*REG_DATA_W-1:0] req_data;
  logic                          claim_valid;
  reg_addr_t                     claim_reg;
  logic                          wr_en;
  reg_addr_t                     wr_reg;
  reg_data_t                     wr_data;
  logic [NUM_REGS-1:0]           busy_mask;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clock       (clock),
    .ctrl_reset  (ctrl_reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_reg     (req_reg),
    .req_data    (req_data),
    .claim_valid (claim_valid),
    .claim_reg   (claim_reg),
    .wr_en       (wr_en),
    .wr_reg      (wr_reg),
    .wr_data     (wr_data),
    .busy_mask   (busy_mask)
  );

  typedef struct {
    reg_addr_t r;
    reg_data_t d;
    int        c;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_err    = 0;
  int  cyc      = 0;

  // Behavioural model state: requesters, round-robin pointer, pending set.
  bit        m_valid[NUM_REQ];
  reg_addr_t m_reg[NUM_REQ];
  reg_data_t m_data[NUM_REQ];
  int        m_last = NUM_REQ - 1;
  logic [NUM_REGS-1:0] m_busy = '0;
  bit        commit_pending = 1'b0;
  reg_addr_t commit_reg = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every wr_en pulse must match the oldest expected write in its cycle.
  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wr_en_unexpected", 64'(wr_en), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_reg_data", {27'd0, wr_reg, wr_data}, {27'd0, mon_e.r, mon_e.d});
        check("write_cycle", 64'(cyc), 64'(mon_e.c));
      end
    end else if (exp_q.size() != 0 && exp_q[0].c <= cyc) begin
      mon_e = exp_q.pop_front();
      check("wr_en_missing", 64'(wr_en), 64'd1);
    end
  end

  // One clock cycle: drive, check req_ready, advance the model, check busy_mask.
  // Called at posedge+1, returns at the next posedge+1.
  task automatic run_cycle(input logic rst, input logic cv, input reg_addr_t cr);
    int                  g;
    logic [NUM_REQ-1:0]  exp_ready;
    logic [NUM_REGS-1:0] nb;
    ctrl_reset  = rst;
    claim_valid = cv;
    claim_reg   = cr;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = m_valid[i];
      req_reg[i*REG_ADDR_W +: REG_ADDR_W]  = m_reg[i];
      req_data[i*REG_DATA_W +: REG_DATA_W] = m_data[i];
    end
    #2;
    g = -1;
    if (!rst) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (g < 0 && m_valid[(m_last + k) % NUM_REQ]) g = (m_last + k) % NUM_REQ;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));

    nb = m_busy;
    if (commit_pending) nb[commit_reg] = 1'b0;
    if (cv && cr != 0) nb[cr] = 1'b1;
    commit_pending = 1'b0;
    if (rst) begin
      nb     = '0;
      m_last = NUM_REQ - 1;
    end else if (g >= 0) begin
      m_last     = g;
      m_valid[g] = 1'b0;
      if (m_reg[g] != 0) begin
        commit_pending = 1'b1;
        commit_reg     = m_reg[g];
        exp_q.push_back('{r: m_reg[g], d: m_data[g], c: cyc + 1});
      end
    end
    m_busy = nb;
    @(posedge clock);
    #1;
    check("busy_mask", 64'(busy_mask), 64'(m_busy));
  endtask

  task automatic present(input int i, input reg_addr_t r, input reg_data_t d);
    m_valid[i] = 1'b1;
    m_reg[i]   = r;
    m_data[i]  = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      m_valid[i] = 1'b0;
      m_reg[i]   = '0;
      m_data[i]  = '0;
    end
    ctrl_reset  = 1'b1;
    claim_valid = 1'b0;
    claim_reg   = '0;
    req_valid   = '0;
    req_reg     = '0;
    req_data    = '0;
    @(posedge clock);
    #1;

    // Reset defaults.
    run_cycle(1'b1, 1'b0, 5'd0);
    run_cycle(1'b1, 1'b0, 5'd0);
    check("reset_wr_en", 64'(wr_en), 64'd0);
    check("reset_wr_reg", 64'(wr_reg), 64'd0);
    check("reset_wr_data", 64'(wr_data), 64'd0);
    run_cycle(1'b0, 1'b0, 5'd0);
    present(0, 5'd3, 32'h1111_1111);
    present(1, 5'd4, 32'h2222_2222);
    run_cycle(1'b0, 1'b0, 5'd0);
    run_cycle(1'b0, 1'b0, 5'd0);

    // Fairness: both held valid for four back-to-back handshakes.
    for (int n = 0; n < 4; n++) begin
      present(0, 5'd5, 32'hAAAA_0000);
      present(1, 5'd6, 32'h5555_FFFF);
      run_cycle(1'b0, 1'b0, 5'd0);
    end
    m_valid[0] = 1'b0;
    m_valid[1] = 1'b0;
    run_cycle(1'b0, 1'b0, 5'd0);

    // Register 0: handshake happens, write is suppressed.
    present(0, 5'd0, 32'hDEAD_BEEF);
    run_cycle(1'b0, 1'b0, 5'd0);
    run_cycle(1'b0, 1'b0, 5'd0);
    run_cycle(1'b0, 1'b1, 5'd0);

    // Scoreboard set, clear, and same-edge claim versus clear.
    run_cycle(1'b0, 1'b1, 5'd7);
    present(1, 5'd7, 32'h0000_0777);
    run_cycle(1'b0, 1'b0, 5'd0);
    run_cycle(1'b0, 1'b0, 5'd0);
    run_cycle(1'b0, 1'b0, 5'd0);
    run_cycle(1'b0, 1'b1, 5'd7);
    present(1, 5'd7, 32'h0000_0778);
    run_cycle(1'b0, 1'b0, 5'd0);
    run_cycle(1'b0, 1'b1, 5'd7);
    run_cycle(1'b0, 1'b1, 5'd7);
    present(0, 5'd7, 32'h0000_0779);
    run_cycle(1'b0, 1'b0, 5'd0);
    run_cycle(1'b0, 1'b0, 5'd0);
    run_cycle(1'b0, 1'b0, 5'd0);

    // Reset mid-operation with requester 0 last granted.
    present(0, 5'd2, 32'h0000_0002);
    run_cycle(1'b0, 1'b1, 5'd12);
    present(0, 5'd9, 32'h0000_0009);
    present(1, 5'd10, 32'h0000_000A);
    run_cycle(1'b1, 1'b0, 5'd0);
    run_cycle(1'b0, 1'b0, 5'd0);
    run_cycle(1'b0, 1'b0, 5'd0);

    // Randomised traffic.
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!m_valid[i] && $urandom_range(0, 1) == 1)
          present(i, reg_addr_t'($urandom_range(0, NUM_REGS - 1)), reg_data_t'($urandom));
      end
      run_cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                reg_addr_t'($urandom_range(0, NUM_REGS - 1)));
    end

    for (int i = 0; i < NUM_REQ; i++) m_valid[i] = 1'b0;
    for (int n = 0; n < 4; n++) run_cycle(1'b0, 1'b0, 5'd0);
    check("queue_drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
